// File: rtl/mems_pkg.sv
// Shared definitions for the MEMS mirror DAC SPI master: FSM states,
// default frame geometry and a small sizing helper.
package mems_pkg;

  localparam int DATA_W_DEF  = 24;
  localparam int CLK_DIV_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    HOLD,
    LDAC
  } state_t;

  // Largest of three wait lengths, used to size the shared wait counter.
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mems_dac_spi_if.sv
// Handshake between mems_control and the DAC SPI master:
// start pulse, waveform-ROM word and the busy flag that paces mems_control.
interface mems_dac_spi_if
  import mems_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic [DATA_W-1:0] romData;
  logic              busy;

  modport master (output start, output romData, input busy);
  modport slave  (input start, input romData, output busy);

endinterface

// File: rtl/mems_sclk_div.sv
// SCLK half-period divider: counts CLK_DIV cycles per half period while
// enabled and flags the edge that ends the low half (rise) and the edge that
// ends the high half (fall / end of bit). Held cleared whenever disabled so
// every frame starts with a full low half-period.
module mems_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic riseEn_o,
  output logic fallEn_o
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             halfEnd;

  assign halfEnd  = en_i && (cnt_q == HALF_LAST);
  assign riseEn_o = halfEnd && !phase_q;
  assign fallEn_o = halfEnd && phase_q;

  // Next count/phase: wrap at the end of each half period, clear when idle.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (en_i) begin
      if (halfEnd) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mems_dac_spi.sv
// SPI master for the MEMS mirror DAC. Each start pulse fetches the current
// waveform-ROM word and shifts it MSB first; busy paces mems_control.
// Optional feature macro: MEMS_DAC_LDAC_EN adds the ldacN_o load strobe and
// the LDAC state after the inter-frame hold.
module mems_dac_spi
  import mems_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int ROM_LAT = 1,
  parameter int CS_GAP  = 2,
  parameter int LDAC_W  = 2
) (
  input  logic          clk,
  input  logic          rst,
  mems_dac_spi_if.slave bus,
  output logic          sclk_o,
  output logic          mosi_o,
`ifdef MEMS_DAC_LDAC_EN
  output logic          syncN_o,
  output logic          ldacN_o
`else
  output logic          syncN_o
`endif
);

  localparam int WAIT_W = $clog2(maxOf3(ROM_LAT, CS_GAP, LDAC_W) + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [WAIT_W-1:0] FETCH_LAST = WAIT_W'(ROM_LAT - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(CS_GAP - 1);
`ifdef MEMS_DAC_LDAC_EN
  localparam logic [WAIT_W-1:0] LDAC_LAST  = WAIT_W'(LDAC_W - 1);
`endif
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [BIT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              syncN_q, syncN_d;
  logic              riseEn, fallEn;
`ifdef MEMS_DAC_LDAC_EN
  logic              ldacN_q, ldacN_d;
`endif

  mems_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclkDiv (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == SHIFT),
    .riseEn_o (riseEn),
    .fallEn_o (fallEn)
  );

  assign bus.busy = busy_q;
  assign sclk_o   = sclk_q;
  assign mosi_o   = shift_q[DATA_W-1];
  assign syncN_o  = syncN_q;
`ifdef MEMS_DAC_LDAC_EN
  assign ldacN_o  = ldacN_q;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured from IDLE, so requests while busy vanish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = FETCH;
      FETCH: if (waitCnt_q == FETCH_LAST) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: if (fallEn && (bitCnt_q == BIT_LAST)) state_d = HOLD;
`ifdef MEMS_DAC_LDAC_EN
      HOLD:  if (waitCnt_q == GAP_LAST) state_d = LDAC;
      LDAC:  if (waitCnt_q == LDAC_LAST) state_d = IDLE;
`else
      HOLD:  if (waitCnt_q == GAP_LAST) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Next registered outputs: the ROM word is captured only on entry to LOAD,
  // and mosi (shift MSB) moves only with the SCLK rising edge.
  always_comb begin
    busy_d  = (state_d != IDLE);
    sclk_d  = sclk_q;
    syncN_d = syncN_q;
    shift_d = shift_q;
    case (state_q)
      FETCH: begin
        if (state_d == LOAD) begin
          shift_d = bus.romData;
          syncN_d = 1'b0;
        end
      end
      LOAD: sclk_d = 1'b0;
      SHIFT: begin
        if (riseEn) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
        end else if (fallEn) begin
          if (state_d == HOLD) syncN_d = 1'b1;
          else                 sclk_d  = 1'b0;
        end
      end
      default: begin
        sclk_d  = 1'b1;
        syncN_d = 1'b1;
      end
    endcase
`ifdef MEMS_DAC_LDAC_EN
    ldacN_d = (state_d != LDAC);
`endif
  end

  // Wait and bit counters restart on every state change.
  always_comb begin
    waitCnt_d = '0;
    if ((state_d == state_q) &&
        ((state_q == FETCH) || (state_q == HOLD) || (state_q == LDAC)))
      waitCnt_d = waitCnt_q + WAIT_W'(1);
    bitCnt_d = '0;
    if ((state_q == SHIFT) && (state_d == SHIFT))
      bitCnt_d = fallEn ? (bitCnt_q + BIT_W'(1)) : bitCnt_q;
  end

  // Datapath and output registers; reset drops the partial word and idles the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b1;
      syncN_q   <= 1'b1;
`ifdef MEMS_DAC_LDAC_EN
      ldacN_q   <= 1'b1;
`endif
    end else begin
      waitCnt_q <= waitCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      syncN_q   <= syncN_d;
`ifdef MEMS_DAC_LDAC_EN
      ldacN_q   <= ldacN_d;
`endif
    end
  end

endmodule

// File: tb/tb_mems_dac_spi.sv
// Directed bench for mems_dac_spi (DATA_W=24, CLK_DIV=4, ROM_LAT=1, CS_GAP=2).
// Honours MEMS_DAC_LDAC_EN for the load-strobe variant.
module tb_mems_dac_spi;

`ifdef MEMS_DAC_LDAC_EN
  localparam int EXP_BUSY = 198;
  localparam int EXP_TAIL = 4;
`else
  localparam int EXP_BUSY = 196;
  localparam int EXP_TAIL = 2;
`endif
  localparam int EXP_GAP = EXP_TAIL + 2;

  logic clk = 1'b0;
  logic rst;
  logic sclk, mosi, syncN, ldacN;

  int compared   = 0;
  int mismatched = 0;

  mems_dac_spi_if #(.DATA_W(24)) bus ();

  mems_dac_spi #(
    .DATA_W  (24),
    .CLK_DIV (4),
    .ROM_LAT (1),
    .CS_GAP  (2),
    .LDAC_W  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sclk_o  (sclk),
    .mosi_o  (mosi),
`ifdef MEMS_DAC_LDAC_EN
    .syncN_o (syncN),
    .ldacN_o (ldacN)
`else
    .syncN_o (syncN)
`endif
  );

`ifndef MEMS_DAC_LDAC_EN
  assign ldacN = 1'b1;
`endif

  always #5 clk = ~clk;

  // One comparison: count it, flag and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one frame from the current negedge and watch it cycle by cycle
  // until busy drops (bounded). Inputs are driven and outputs sampled on negedges.
  task automatic applyStimulus(
    input  logic [23:0] word,
    input  int          startHold,
    input  int          midPulse,
    input  int          chgCycle,
    input  logic [23:0] chgWord,
    output logic [23:0] got,
    output int          falls,
    output int          busyLen,
    output int          leadHigh,
    output int          tailHigh,
    output int          ldacLow,
    output int          ldacDelay,
    output bit          done
  );
    bit   seenBusy, seenLow;
    logic prevSclk, prevSync;
    int   syncRise, ldacFirst;
    got = '0; falls = 0; busyLen = 0; leadHigh = 0; tailHigh = 0; ldacLow = 0;
    done = 0; seenBusy = 0; seenLow = 0; prevSclk = sclk; prevSync = syncN;
    syncRise = -1; ldacFirst = -1;
    bus.romData = word;
    bus.start   = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (!bus.busy && seenBusy) begin
        done = 1;
        break;
      end
      if (bus.busy) begin
        seenBusy = 1;
        busyLen++;
        if (syncN && !seenLow) leadHigh++;
        if (syncN && seenLow) tailHigh++;
      end
      if (!syncN) seenLow = 1;
      if (prevSclk && !sclk && !syncN) begin
        falls++;
        got = {got[22:0], mosi};
      end
      if (!prevSync && syncN && syncRise < 0) syncRise = c;
      if (!ldacN) begin
        ldacLow++;
        if (ldacFirst < 0) ldacFirst = c;
      end
      prevSclk = sclk;
      prevSync = syncN;
      bus.start = (c < startHold) || (c == midPulse);
      if (c == chgCycle) bus.romData = chgWord;
    end
    bus.start = 1'b0;
    ldacDelay = ldacFirst - syncRise;
  endtask

  logic [23:0] got;
  int falls, busyLen, leadHigh, tailHigh, ldacLow, ldacDelay, tail1, idleBusy, fallCnt;
  bit done;
  logic prev;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.romData = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_sclk", sclk, 1);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_syncN", syncN, 1);
    checkOutput("rst_ldacN", ldacN, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single frame A5C3F0");
    applyStimulus(24'hA5C3F0, 1, -1, -1, 24'h0, got, falls, busyLen, leadHigh, tailHigh,
                  ldacLow, ldacDelay, done);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_busyLen", busyLen, EXP_BUSY);
    checkOutput("t1_falls", falls, 24);
    checkOutput("t1_word", got, 24'hA5C3F0);
    checkOutput("t1_leadHigh", leadHigh, 1);
    checkOutput("t1_tailHigh", tailHigh, EXP_TAIL);
    checkOutput("t1_endSync", syncN, 1);
    checkOutput("t1_endSclk", sclk, 1);
`ifdef MEMS_DAC_LDAC_EN
    checkOutput("t6_ldacLow", ldacLow, 2);
    checkOutput("t6_ldacDelay", ldacDelay, 2);
`endif
    repeat (3) @(negedge clk);

    $display("[TB] held start plus mid-shift start");
    applyStimulus(24'h3C5A96, 3, 100, -1, 24'h0, got, falls, busyLen, leadHigh, tailHigh,
                  ldacLow, ldacDelay, done);
    checkOutput("t2_busyLen", busyLen, EXP_BUSY);
    checkOutput("t2_falls", falls, 24);
    checkOutput("t2_word", got, 24'h3C5A96);
    idleBusy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy) idleBusy++;
    end
    checkOutput("t2_noSecondFrame", idleBusy, 0);

    $display("[TB] back-to-back frames");
    applyStimulus(24'h000000, 1, -1, -1, 24'h0, got, falls, busyLen, leadHigh, tailHigh,
                  ldacLow, ldacDelay, done);
    checkOutput("t3a_word", got, 24'h000000);
    checkOutput("t3a_falls", falls, 24);
    tail1 = tailHigh;
    applyStimulus(24'hFFFFFF, 1, -1, -1, 24'h0, got, falls, busyLen, leadHigh, tailHigh,
                  ldacLow, ldacDelay, done);
    checkOutput("t3b_word", got, 24'hFFFFFF);
    checkOutput("t3b_falls", falls, 24);
    checkOutput("t3_syncGap", tail1 + 1 + leadHigh, EXP_GAP);
    repeat (3) @(negedge clk);

    $display("[TB] rom_data change after LOAD");
    applyStimulus(24'h5A0F3C, 1, -1, 3, 24'h123456, got, falls, busyLen, leadHigh, tailHigh,
                  ldacLow, ldacDelay, done);
    checkOutput("t4_word", got, 24'h5A0F3C);
    checkOutput("t4_busyLen", busyLen, EXP_BUSY);
    repeat (3) @(negedge clk);

    $display("[TB] reset at 10th sclk fall");
    bus.romData = 24'h0F0F0F;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    fallCnt = 0;
    prev = sclk;
    for (int c = 0; c < 400 && fallCnt < 10; c++) begin
      @(negedge clk);
      if (prev && !sclk) fallCnt++;
      prev = sclk;
    end
    checkOutput("t5_reach10", fallCnt, 10);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_syncN", syncN, 1);
    checkOutput("t5_sclk", sclk, 1);
    checkOutput("t5_busy", bus.busy, 0);
    checkOutput("t5_mosi", mosi, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(24'hC0FFEE, 1, -1, -1, 24'h0, got, falls, busyLen, leadHigh, tailHigh,
                  ldacLow, ldacDelay, done);
    checkOutput("t5_word", got, 24'hC0FFEE);
    checkOutput("t5_falls", falls, 24);
    checkOutput("t5_busyLen", busyLen, EXP_BUSY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
